// File: rtl/mem_channel_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_channel_arbiter_if
//
// Bundles every handshake/bus signal around the memory channel arbiter: the
// NUM_CONSUMERS flattened request ports on the upstream side and the single
// consumer channel of the memory controller on the downstream side.
//
// Signal summary (consumer i occupies slice [i*W +: W] of flattened buses):
//   consumer_read_valid    [NUM_CONSUMERS]            consumer -> arbiter
//   consumer_read_address  [NUM_CONSUMERS*ADDR_BITS]  consumer -> arbiter
//   consumer_read_ready    [NUM_CONSUMERS]            arbiter  -> consumer
//   consumer_read_data     [NUM_CONSUMERS*DATA_BITS]  arbiter  -> consumer
//   consumer_write_valid   [NUM_CONSUMERS]            consumer -> arbiter
//   consumer_write_address [NUM_CONSUMERS*ADDR_BITS]  consumer -> arbiter
//   consumer_write_data    [NUM_CONSUMERS*DATA_BITS]  consumer -> arbiter
//   consumer_write_ready   [NUM_CONSUMERS]            arbiter  -> consumer
//   ctrl_read_valid / ctrl_read_address               arbiter  -> controller
//   ctrl_read_ready / ctrl_read_data                  controller -> arbiter
//   ctrl_write_valid / ctrl_write_address / ctrl_write_data
//                                                     arbiter  -> controller
//   ctrl_write_ready                                  controller -> arbiter
//
// Modports:
//   master : the arbiter itself (masters the controller channel and answers
//            the consumers).
//   slave  : the surrounding agents (consumers plus memory controller).
// -----------------------------------------------------------------------------
interface mem_channel_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
);

  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

  logic                               ctrl_read_valid;
  logic [ADDR_BITS-1:0]               ctrl_read_address;
  logic                               ctrl_read_ready;
  logic [DATA_BITS-1:0]               ctrl_read_data;
  logic                               ctrl_write_valid;
  logic [ADDR_BITS-1:0]               ctrl_write_address;
  logic [DATA_BITS-1:0]               ctrl_write_data;
  logic                               ctrl_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output ctrl_read_valid, ctrl_read_address,
    output ctrl_write_valid, ctrl_write_address, ctrl_write_data,
    input  ctrl_read_ready, ctrl_read_data, ctrl_write_ready
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  ctrl_read_valid, ctrl_read_address,
    input  ctrl_write_valid, ctrl_write_address, ctrl_write_data,
    output ctrl_read_ready, ctrl_read_data, ctrl_write_ready
  );

endinterface : mem_channel_arbiter_if

// File: rtl/mem_channel_arbiter.sv
// -----------------------------------------------------------------------------
// mem_channel_arbiter
//
// Round-robin arbiter merging NUM_CONSUMERS read/write request ports onto the
// single consumer channel of the memory controller. One transaction (read or
// write) is outstanding at a time. A consumer requesting both a read and a
// write is served the read first; the write stays pending for a later grant.
//
// Flow: IDLE picks the first requester at or above rr_ptr (with wrap) and
// launches the request downstream; WAIT holds it until the controller answers
// and forwards the answer to the granted consumer; RELAY holds the consumer
// ready until both the consumer valid and the controller ready have dropped,
// then advances rr_ptr past the granted index.
//
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : synchronous, active-high reset
//   bus   : mem_channel_arbiter_if.master (consumer ports + controller port)
//
// Every output is a register; no combinational path runs input to output.
// -----------------------------------------------------------------------------
module mem_channel_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_channel_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CONSUMERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RELAY = 2'd2
  } state_t;

  state_t                             state_q, state_d;
  logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                   grant_q, grant_d;
  logic                               op_write_q, op_write_d;

  logic                               ctrl_read_valid_q, ctrl_read_valid_d;
  logic [ADDR_BITS-1:0]               ctrl_read_address_q, ctrl_read_address_d;
  logic                               ctrl_write_valid_q, ctrl_write_valid_d;
  logic [ADDR_BITS-1:0]               ctrl_write_address_q, ctrl_write_address_d;
  logic [DATA_BITS-1:0]               ctrl_write_data_q, ctrl_write_data_d;

  logic [NUM_CONSUMERS-1:0]           cons_read_ready_q, cons_read_ready_d;
  logic [NUM_CONSUMERS-1:0]           cons_write_ready_q, cons_write_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] cons_read_data_q, cons_read_data_d;

  // ---------------------------------------------------------------------------
  // Round-robin search: first requesting index at or above rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  logic [NUM_CONSUMERS-1:0] requesting;
  logic                     pick_found;
  logic [PTR_W-1:0]         pick_idx;
  logic [SUM_W-1:0]         rr_sum;

  assign requesting = bus.consumer_read_valid | bus.consumer_write_valid;

  // NOTE: every variable assigned in an always_comb gets a default at the top;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_sum     = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      rr_sum = {1'b0, rr_ptr_q} + SUM_W'(i);
      if (rr_sum >= SUM_W'(NUM_CONSUMERS)) begin
        rr_sum = rr_sum - SUM_W'(NUM_CONSUMERS);
      end
      if (!pick_found && requesting[rr_sum[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = rr_sum[PTR_W-1:0];
      end
    end
  end

  // Handshake state of the granted transaction, selected by the latched op.
  logic grant_valid;
  logic ctrl_ready_op;

  assign grant_valid   = op_write_q ? bus.consumer_write_valid[grant_q]
                                    : bus.consumer_read_valid[grant_q];
  assign ctrl_ready_op = op_write_q ? bus.ctrl_write_ready : bus.ctrl_read_ready;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d              = state_q;
    rr_ptr_d             = rr_ptr_q;
    grant_d              = grant_q;
    op_write_d           = op_write_q;
    ctrl_read_valid_d    = ctrl_read_valid_q;
    ctrl_read_address_d  = ctrl_read_address_q;
    ctrl_write_valid_d   = ctrl_write_valid_q;
    ctrl_write_address_d = ctrl_write_address_q;
    ctrl_write_data_d    = ctrl_write_data_q;
    cons_read_ready_d    = cons_read_ready_q;
    cons_write_ready_d   = cons_write_ready_q;
    cons_read_data_d     = cons_read_data_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_WAIT;
          // Read has priority when a consumer raises both valids.
          if (bus.consumer_read_valid[pick_idx]) begin
            op_write_d          = 1'b0;
            ctrl_read_valid_d   = 1'b1;
            ctrl_read_address_d =
              bus.consumer_read_address[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
          end else begin
            op_write_d           = 1'b1;
            ctrl_write_valid_d   = 1'b1;
            ctrl_write_address_d =
              bus.consumer_write_address[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
            ctrl_write_data_d    =
              bus.consumer_write_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
          end
        end
      end

      ST_WAIT: begin
        if (!op_write_q && bus.ctrl_read_ready) begin
          ctrl_read_valid_d          = 1'b0;
          cons_read_ready_d[grant_q] = 1'b1;
          cons_read_data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = bus.ctrl_read_data;
          state_d                    = ST_RELAY;
        end else if (op_write_q && bus.ctrl_write_ready) begin
          ctrl_write_valid_d          = 1'b0;
          cons_write_ready_d[grant_q] = 1'b1;
          state_d                     = ST_RELAY;
        end
      end

      ST_RELAY: begin
        // Both sides must have closed their handshakes before the next grant;
        // a consumer that dropped valid early just sees a one-cycle ready.
        if (!grant_valid && !ctrl_ready_op) begin
          cons_read_ready_d  = '0;
          cons_write_ready_d = '0;
          rr_ptr_d           = (grant_q == LAST_IDX) ? '0 : grant_q + PTR_W'(1);
          state_d            = ST_IDLE;
        end
      end

      default: begin
        state_d            = ST_IDLE;
        ctrl_read_valid_d  = 1'b0;
        ctrl_write_valid_d = 1'b0;
        cons_read_ready_d  = '0;
        cons_write_ready_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its _d value from before the edge, regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q              <= ST_IDLE;
      rr_ptr_q             <= '0;
      grant_q              <= '0;
      op_write_q           <= 1'b0;
      ctrl_read_valid_q    <= 1'b0;
      ctrl_read_address_q  <= '0;
      ctrl_write_valid_q   <= 1'b0;
      ctrl_write_address_q <= '0;
      ctrl_write_data_q    <= '0;
      cons_read_ready_q    <= '0;
      cons_write_ready_q   <= '0;
      // NOTE: the per-consumer read-data slices are storage, but they drive
      // outputs whose post-reset value is visible, so they are reset too.
      cons_read_data_q     <= '0;
    end else begin
      state_q              <= state_d;
      rr_ptr_q             <= rr_ptr_d;
      grant_q              <= grant_d;
      op_write_q           <= op_write_d;
      ctrl_read_valid_q    <= ctrl_read_valid_d;
      ctrl_read_address_q  <= ctrl_read_address_d;
      ctrl_write_valid_q   <= ctrl_write_valid_d;
      ctrl_write_address_q <= ctrl_write_address_d;
      ctrl_write_data_q    <= ctrl_write_data_d;
      cons_read_ready_q    <= cons_read_ready_d;
      cons_write_ready_q   <= cons_write_ready_d;
      cons_read_data_q     <= cons_read_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (registered)
  // ---------------------------------------------------------------------------
  assign bus.ctrl_read_valid      = ctrl_read_valid_q;
  assign bus.ctrl_read_address    = ctrl_read_address_q;
  assign bus.ctrl_write_valid     = ctrl_write_valid_q;
  assign bus.ctrl_write_address   = ctrl_write_address_q;
  assign bus.ctrl_write_data      = ctrl_write_data_q;
  assign bus.consumer_read_ready  = cons_read_ready_q;
  assign bus.consumer_write_ready = cons_write_ready_q;
  assign bus.consumer_read_data   = cons_read_data_q;

endmodule : mem_channel_arbiter

// File: doc/mem_channel_arbiter.md
# mem_channel_arbiter

Round-robin arbiter that merges NUM_CONSUMERS fetcher/LSU request ports onto the single consumer channel of the memory controller. It sits directly upstream of the controller: consumers see the same valid/ready handshake they would see on the controller itself, and the controller sees exactly one consumer. Exactly one transaction, read or write, is outstanding at a time.

## Interface
Parameters:
- NUM_CONSUMERS, 4, number of upstream request ports (≥2)
- ADDR_BITS, 8, address width
- DATA_BITS, 16, data width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  flattened; consumer i at bits [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  per-consumer read completion
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  flattened read data
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  flattened
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  flattened
- consumer_write_ready  out  NUM_CONSUMERS  per-consumer write completion
- ctrl_read_valid  out  1  read request to controller
- ctrl_read_address  out  ADDR_BITS
- ctrl_read_ready  in  1  controller read completion
- ctrl_read_data  in  DATA_BITS
- ctrl_write_valid  out  1  write request to controller
- ctrl_write_address  out  ADDR_BITS
- ctrl_write_data  out  DATA_BITS
- ctrl_write_ready  in  1  controller write completion

## Operation
- Handshake on both sides: requester raises valid and holds address/data until ready is seen. Responder raises ready and holds it until valid drops, then drops ready.
- Consumer i is "requesting" if read_valid[i] | write_valid[i]. If both are set, read wins. The write stays pending.
- States: IDLE, WAIT, RELAY.
- IDLE: if any consumer is requesting, grant the first requesting index found by searching upward from rr_ptr with wrap modulo NUM_CONSUMERS. Latch grant index and op (read/write). Drive ctrl_*_valid=1 with that consumer's address/data, all registered. Go to WAIT.
- WAIT: on ctrl_read_ready (read) or ctrl_write_ready (write):
  - drop ctrl_*_valid;
  - set consumer_*_ready[grant]=1;
  - for reads, capture ctrl_read_data into the grant's consumer_read_data slice;
  - go to RELAY.
- RELAY: when the granted consumer's valid for the latched op is low AND the controller's ready for that op is low:
  - clear consumer_*_ready[grant];
  - set rr_ptr = (grant+1) mod NUM_CONSUMERS, with wrap from NUM_CONSUMERS-1 to 0;
  - go to IDLE.
- Non-granted consumers' ready outputs stay 0 throughout. Their read_data slices keep their last captured values.
- Consumer deasserting valid before ready is a protocol violation. The arbiter still completes the downstream transaction, pulses ready for the one RELAY cycle, and returns to IDLE.
- Reset: outputs take their reset values, state=IDLE, rr_ptr=0, grant=0. Reset mid-transaction abandons it. The next request restarts arbitration from consumer 0.
- Unknown state encodings return to IDLE.

## Timing
- Reset values: all ctrl_*_valid=0, ctrl addresses/data=0, all consumer_*_ready=0, all consumer_read_data=0.
- Request visible in IDLE at edge N → ctrl_*_valid=1 after edge N.
- Controller ready sampled at edge M → consumer ready=1 and data valid after edge M.
- Arbiter overhead: 1 cycle in, 1 cycle out, plus 1 IDLE cycle between back-to-back grants.
- Minimum spacing between grants is 1 cycle in IDLE. A continuously requesting consumer cannot starve others: grant order rotates.
- All outputs are registers. There is no combinational path from inputs to outputs.

## Test plan
- Single read: consumer 2 reads addr 0x3C, controller returns 0x1234 → ctrl_read_address=0x3C, consumer_read_ready[2]=1 with data 0x1234. Other ready bits stay 0. rr_ptr becomes 3.
- Single write: consumer 0 writes 0xBEEF to 0x10 → ctrl_write_valid with addr 0x10 and data 0xBEEF. consumer_write_ready[0] asserts and drops one cycle after write_valid[0] drops.
- Round robin: all 4 consumers read continuously from reset → grant order 0,1,2,3,0. Each ready appears only for its own index.
- Wrap: rr_ptr=3, only consumers 1 and 3 requesting → grant 3, then 1.
- Read/write conflict: consumer 1 asserts both read (0x05) and write (0x06, 0xAAAA) → read served first, then write on a later grant.
- Reset mid-WAIT: assert reset while ctrl_read_valid=1 → next cycle all valids/readies 0, state IDLE. A fresh request from consumer 3 is granted normally.
